// File: rtl/router_fifo.sv
// router_fifo: per-destination output buffer of the 1x3 router.
//
// Stores bytes from the register stage together with a header tag
// (lfd_state), delivers them in order with one cycle of read latency and
// tracks how many bytes of the packet currently being read remain.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   soft_rst       synchronous flush request, overrides we/re
//   we, re         write / read enable
//   lfd_state      current write is the header byte (stored as tag bit)
//   din            write data
//   dout           registered read data
//   full, empty    occupancy flags, combinational from the pointers
//   timeout_flush  one-cycle pulse of the idle flush (optional build only)
//   pkt_busy       bytes of the current packet remain to be read
//
// Optional build: define ROUTER_FIFO_TIMEOUT_EN to add an idle-read
// counter that flushes the FIFO after TIMEOUT cycles without a read while
// data is waiting, and to add the timeout_flush output.
module router_fifo #(
    parameter int DEPTH   = 16,
    parameter int WIDTH   = 8,
    parameter int PTR_W   = 4,
    parameter int TIMEOUT = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_rst,
    input  logic             we,
    input  logic             re,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
`ifdef ROUTER_FIFO_TIMEOUT_EN
    output logic             timeout_flush,
`endif
    output logic             pkt_busy
);

    localparam int CNT_W = PTR_W + 3;

    if (DEPTH != (1 << PTR_W)) begin : g_bad_depth
        $error("router_fifo: DEPTH must equal 2**PTR_W");
    end
    if (WIDTH < 3) begin : g_bad_width
        $error("router_fifo: WIDTH must be at least 3");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("router_fifo: TIMEOUT must be at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] tag;
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [CNT_W-1:0] count;
    logic             clr_pending;   // parity byte shown, clear dout next idle cycle
    logic             wr_ok;
    logic             rd_ok;
    logic             flush;
    logic             to_fire;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;

    assign wr_idx = wr_ptr[PTR_W-1:0];
    assign rd_idx = rd_ptr[PTR_W-1:0];

    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);
    assign empty = (wr_ptr == rd_ptr);

    assign wr_ok    = we && !full;
    assign rd_ok    = re && !empty;
    assign flush    = soft_rst || to_fire;
    assign pkt_busy = (count != '0);

`ifdef ROUTER_FIFO_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT);

    logic [IDLE_W-1:0] idle_cnt;

    assign to_fire       = !empty && (idle_cnt == IDLE_W'(TIMEOUT - 1));
    assign timeout_flush = to_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (flush || empty || rd_ok) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end
`else
    assign to_fire = 1'b0;
`endif

    // Data payload carries no reset; only the tag bits are cleared.
    always_ff @(posedge clk) begin
        if (wr_ok && !flush) begin
            mem[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag         <= '0;
            dout        <= '0;
            count       <= '0;
            clr_pending <= 1'b0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag         <= '0;
            dout        <= '0;
            count       <= '0;
            clr_pending <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr      <= wr_ptr + 1'b1;
                tag[wr_idx] <= lfd_state;
            end

            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_idx];
                if (tag[rd_idx]) begin
                    // Header: payload length field plus the parity byte.
                    count       <= CNT_W'(mem[rd_idx][WIDTH-1:2]) + CNT_W'(1);
                    clr_pending <= 1'b0;
                end else if (count != '0) begin
                    count       <= count - CNT_W'(1);
                    clr_pending <= (count == CNT_W'(1));
                end else begin
                    clr_pending <= 1'b0;
                end
            end else if (clr_pending) begin
                // Parity byte was displayed for one cycle; blank the output.
                dout        <= '0;
                clr_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
module tb_router_fifo;

    localparam int S_DOUT  = 0;
    localparam int S_FULL  = 1;
    localparam int S_EMPTY = 2;
    localparam int S_BUSY  = 3;
    localparam int S_TFL   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       soft_rst = 1'b0;
    logic       we = 1'b0;
    logic       re = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic       pkt_busy;
`ifdef ROUTER_FIFO_TIMEOUT_EN
    logic       timeout_flush;
`endif

    router_fifo #(
        .DEPTH   (16),
        .WIDTH   (8),
        .PTR_W   (4),
        .TIMEOUT (30)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .soft_rst      (soft_rst),
        .we            (we),
        .re            (re),
        .lfd_state     (lfd_state),
        .din           (din),
        .dout          (dout),
        .full          (full),
        .empty         (empty),
`ifdef ROUTER_FIFO_TIMEOUT_EN
        .timeout_flush (timeout_flush),
`endif
        .pkt_busy      (pkt_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        int         sig;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] sample(input int sig);
        case (sig)
            S_DOUT:  return dout;
            S_FULL:  return {7'b0, full};
            S_EMPTY: return {7'b0, empty};
            S_BUSY:  return {7'b0, pkt_busy};
`ifdef ROUTER_FIFO_TIMEOUT_EN
            S_TFL:   return {7'b0, timeout_flush};
`endif
            default: return 8'hxx;
        endcase
    endfunction

    // Monitor: outputs are checked one cycle after the stimulus that caused them.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk(e.name, sample(e.sig), e.val);
        end
    end

    task automatic drive(input logic w, input logic r, input logic l,
                         input logic [7:0] d, input logic s);
        @(negedge clk);
        we        = w;
        re        = r;
        lfd_state = l;
        din       = d;
        soft_rst  = s;
    endtask

    task automatic want(input int sig, input logic [7:0] v, input string n);
        exp_t e;
        e.due  = cyc + 1;
        e.sig  = sig;
        e.val  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    logic [7:0] pk [16];

    initial begin
        #1;
        chk("rst0_empty", {7'b0, empty}, 8'h01);
        chk("rst0_full",  {7'b0, full},  8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-operation with 5 entries stored and dout non-zero
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 8'hA1 + 8'(i), 0);
        drive(0, 1, 0, 8'h00, 0); want(S_DOUT, 8'hA1, "t1_rd_a1");
        drive(1, 0, 0, 8'hA6, 0);
        drive(0, 0, 0, 8'h00, 0); want(S_EMPTY, 8'h00, "t1_not_empty");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t1_rst_empty", {7'b0, empty},    8'h01);
        chk("t1_rst_full",  {7'b0, full},     8'h00);
        chk("t1_rst_dout",  dout,             8'h00);
        chk("t1_rst_busy",  {7'b0, pkt_busy}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Full packet: header 3A (length 14), 14 payload bytes, parity 5C
        pk[0] = 8'h3A;
        for (int i = 1; i < 15; i++) pk[i] = 8'h10 + 8'(i);
        pk[15] = 8'h5C;
        drive(1, 0, 1, pk[0], 0);
        for (int i = 1; i < 16; i++) drive(1, 0, 0, pk[i], 0);
        want(S_FULL, 8'h01, "t2_full");
        for (int k = 0; k < 16; k++) begin
            drive(0, 1, 0, 8'h00, 0);
            want(S_DOUT, pk[k], "t2_dout");
            want(S_BUSY, (k < 15) ? 8'h01 : 8'h00, "t2_busy");
        end
        drive(0, 0, 0, 8'h00, 0);
        want(S_DOUT,  8'h00, "t2_dout_clear");
        want(S_EMPTY, 8'h01, "t2_empty");

        // Fill to full, dropped 17th write, drain
        for (int i = 1; i <= 16; i++) drive(1, 0, 0, 8'(i), 0);
        want(S_FULL, 8'h01, "t3_full");
        drive(1, 0, 0, 8'hFF, 0); want(S_FULL, 8'h01, "t3_drop_full");
        for (int i = 1; i <= 16; i++) begin
            drive(0, 1, 0, 8'h00, 0);
            want(S_DOUT, 8'(i), "t3_dout");
            if (i == 1)  want(S_FULL,  8'h00, "t3_not_full");
            if (i == 16) want(S_EMPTY, 8'h01, "t3_empty");
        end
        drive(0, 0, 0, 8'h00, 0); want(S_DOUT, 8'h10, "t3_dout_hold");

        // Simultaneous we/re when full, then when empty (pointers wrap here)
        for (int i = 0; i < 16; i++) drive(1, 0, 0, 8'h20 + 8'(i), 0);
        want(S_FULL, 8'h01, "t4_full");
        drive(1, 1, 0, 8'hEE, 0);
        want(S_DOUT, 8'h20, "t4_full_rw_dout");
        want(S_FULL, 8'h00, "t4_full_rw_full");
        for (int i = 1; i < 16; i++) begin
            drive(0, 1, 0, 8'h00, 0);
            want(S_DOUT, 8'h20 + 8'(i), "t4_dout");
        end
        want(S_EMPTY, 8'h01, "t4_no_write_through");
        drive(1, 1, 0, 8'h77, 0);
        want(S_DOUT,  8'h2F, "t4_no_bypass");
        want(S_EMPTY, 8'h00, "t4_empty_rw_write");
        drive(0, 1, 0, 8'h00, 0);
        want(S_DOUT,  8'h77, "t4_rd_77");
        want(S_EMPTY, 8'h01, "t4_empty");

        // soft_rst overrides concurrent we/re
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 8'hB1 + 8'(i), 0);
        drive(1, 1, 0, 8'hCC, 1);
        want(S_EMPTY, 8'h01, "t5_empty");
        want(S_DOUT,  8'h00, "t5_dout");
        want(S_FULL,  8'h00, "t5_full");
        drive(0, 0, 0, 8'h00, 0); want(S_EMPTY, 8'h01, "t5_no_write");
        drive(1, 0, 0, 8'hD1, 0);
        drive(0, 1, 0, 8'h00, 0); want(S_DOUT, 8'hD1, "t5_after_flush");

        // One entry left unread for 30 cycles
        drive(1, 0, 0, 8'hE5, 0);
        for (int i = 1; i <= 30; i++) begin
            drive(0, 0, 0, 8'h00, 0);
`ifdef ROUTER_FIFO_TIMEOUT_EN
            want(S_TFL,   (i == 29) ? 8'h01 : 8'h00, "t6_tflush");
            want(S_EMPTY, (i >= 30) ? 8'h01 : 8'h00, "t6_empty");
`else
            want(S_EMPTY, 8'h00, "t6_retained");
`endif
        end
`ifdef ROUTER_FIFO_TIMEOUT_EN
        want(S_DOUT, 8'h00, "t6_dout_flushed");
        drive(0, 0, 0, 8'h00, 0);
        want(S_TFL, 8'h00, "t6_single_pulse");
`else
        drive(0, 1, 0, 8'h00, 0); want(S_DOUT, 8'hE5, "t6_rd_e5");
`endif
        drive(0, 0, 0, 8'h00, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- Per-destination output buffer of the 1x3 router; one instance per output port.
- Captures bytes from the register stage (dout of the register block) when the FSM asserts a write enable, and tags the header byte using lfd_state.
- Delivers bytes in order to the destination reader and tracks the remaining byte count of the packet currently being read.
- full feeds back to the FSM/register stage as fifofull; empty goes to the destination as "data available".

Parameters:
- DEPTH, 16, number of entries; must be a power of 2.
- WIDTH, 8, data byte width.
- PTR_W, 4, log2(DEPTH).
- TIMEOUT, 30, idle-read cycle limit; used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- soft_rst  in  1  synchronous flush request from the synchronizer, active-high.
- we  in  1  write enable.
- re  in  1  read enable.
- lfd_state  in  1  current write is the header byte; stored as tag bit WIDTH.
- din  in  WIDTH  write data.
- dout  out  WIDTH  registered read data.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- pkt_busy  out  1  bytes of the current packet remain to be read.

Behaviour:
- Storage is DEPTH x (WIDTH+1); bit WIDTH is the header tag.
- Pointers wr_ptr and rd_ptr are PTR_W+1 bits and carry a wrap bit.
- full when the pointer MSBs differ and the low PTR_W bits are equal; empty when the pointers are equal.
- full and empty are combinational from the pointers.
- rst (asynchronous): pointers = 0, dout = 0, pkt count = 0, all tag bits = 0, timeout counter = 0. Data contents are don't-care.
- soft_rst (synchronous) has the same effect as rst and overrides we/re in the same cycle.
- Write:
  - When we=1 and full=0, mem[wr_ptr] <= {lfd_state, din} and wr_ptr increments.
  - When we=1 and full=1, the write is dropped and nothing changes.
- Read:
  - When re=1 and empty=0, dout <= mem[rd_ptr][WIDTH-1:0] on that edge (1-cycle latency) and rd_ptr increments.
  - When re=1 and empty=1, nothing changes and dout holds its value.
- Simultaneous we and re:
  - Both are performed if their individual conditions hold.
  - When full, only the read happens; there is no write-through.
  - When empty, only the write happens; there is no read bypass.
- Pointer wrap: after DEPTH operations the low bits return to 0 and the MSB toggles.
- Packet count (PTR_W+3 bits, i.e. 7 bits):
  - Reading a word whose tag = 1 loads count <= data[7:2] + 1 (payload length plus parity byte).
  - Reading a word whose tag = 0 decrements count if count != 0; if count = 0 it stays at 0.
  - pkt_busy = (count != 0).
- When a read makes count 0 (the parity byte), dout still shows that parity byte. On the next cycle with no successful read, dout <= 0.
- No state machine beyond the counters.
- Reset in mid-packet discards everything; the next header written restarts tagging normally.

Optional Feature:
- ROUTER_FIFO_TIMEOUT_EN defined:
  - An idle counter counts cycles where empty=0 and no successful read occurs.
  - It clears on any successful read or when empty=1.
  - When it reaches TIMEOUT-1, the FIFO performs an internal flush on the next edge, identical to soft_rst.
  - Adds an output timeout_flush (1 bit), which pulses for that one cycle.
- Not defined: no idle counter, no extra port, and the FIFO flushes only on rst/soft_rst.

Test Plan:
- rst=1 mid-operation with 5 entries stored -> immediately empty=1, full=0, dout=0, pkt_busy=0.
- Write header 8'h3A with lfd_state=1, then 14 payload bytes, then parity 8'h5C; read all 16 -> dout matches write order at 1-cycle latency; pkt_busy=1 after header read with count 15; count reaches 0 on parity read; dout=0 the following cycle.
- Write 16 bytes 8'h01..8'h10 -> full=1 after the 16th. A 17th write of 8'hFF is dropped. Read 16 -> 8'h01..8'h10, then empty=1.
- FIFO full with we=1 and re=1 together -> one entry read, write ignored, full deasserts. FIFO empty with we=1 and re=1 -> entry written, dout unchanged, empty=0.
- 3 entries stored, soft_rst=1 together with we=1 and re=1 -> next cycle empty=1, dout=0, no write recorded.
- With ROUTER_FIFO_TIMEOUT_EN: 1 entry stored and re held 0 for 30 cycles -> timeout_flush pulses once, then empty=1. Without the macro: the entry is retained indefinitely.
